// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Serialises word/half/byte loads and stores onto an 8-bit byte memory,
//   one byte per cycle, little-endian. It returns a one-cycle completion
//   pulse carrying the sign- or zero-extended load data.
//
//   Optional build macro: MISALIGN_TRAP_EN
//     Defined   : a word with addr[1:0]!=0 or a half with addr[0]!=0 makes no
//                 memory access and completes at once with misalign_err=1.
//     Undefined : misalign_err is tied low and misaligned accesses are done
//                 bytewise with 6-bit address wrap.
//
// Ports
//   clk, rst          : clock; asynchronous active-low reset
//   req_valid/ready   : request handshake (ready only while idle)
//   req_write         : 1 store, 0 load
//   req_size          : 00 word, 01 half, 10 byte, 11 illegal
//   req_signed        : sign-extend load result
//   req_addr          : byte address of the lowest byte
//   req_wdata         : store data
//   resp_valid        : one-cycle completion pulse
//   resp_rdata        : extended load data (0 for stores/illegal)
//   misalign_err      : misaligned-access flag, valid with resp_valid
//   mem_read/mem_write: byte-memory strobes
//   mem_addr/wdata    : byte-memory address / write data
//   mem_rdata         : byte-memory combinational read data
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [5:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] rdata_q, rdata_d;
  logic        trap;

`ifdef MISALIGN_TRAP_EN
  logic        misal_q, misal_d;
  logic        req_misal;
  assign req_misal = ((req_size == 2'b00) && (req_addr[1:0] != 2'b00)) ||
                     ((req_size == 2'b01) && req_addr[0]);
  assign trap = misal_q;
`else
  assign trap = 1'b0;
`endif

  // Index of the final byte of the current access.
  logic [1:0] last_idx;
  always_comb begin
    case (size_q)
      2'b00:   last_idx = 2'd3;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    idx_d    = idx_q;
    rdata_d  = rdata_q;
`ifdef MISALIGN_TRAP_EN
    misal_d  = misal_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          idx_d    = 2'd0;
          rdata_d  = '0;
`ifdef MISALIGN_TRAP_EN
          misal_d  = req_misal;
          state_d  = (req_size == 2'b11 || req_misal) ? RESP : ACCESS;
`else
          state_d  = (req_size == 2'b11) ? RESP : ACCESS;
`endif
        end
      end
      ACCESS: begin
        if (!write_q) rdata_d[{idx_q, 3'b000} +: 8] = mem_rdata;
        if (idx_q == last_idx) state_d = RESP;
        else                   idx_d   = idx_q + 2'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      idx_q    <= '0;
      rdata_q  <= '0;
`ifdef MISALIGN_TRAP_EN
      misal_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      idx_q    <= idx_d;
      rdata_q  <= rdata_d;
`ifdef MISALIGN_TRAP_EN
      misal_q  <= misal_d;
`endif
    end
  end

  // Outputs decode purely from registered state, so reset forces them
  // low immediately, including abandoning a store mid-flight.
  logic in_access;
  assign in_access  = (state_q == ACCESS);
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign mem_read   = in_access & ~write_q;
  assign mem_write  = in_access & write_q;
  assign mem_addr   = in_access ? (addr_q + {4'b0000, idx_q}) : 6'd0;
  assign mem_wdata  = in_access ? wdata_q[{idx_q, 3'b000} +: 8] : 8'd0;

`ifdef MISALIGN_TRAP_EN
  assign misalign_err = resp_valid & trap;
`else
  assign misalign_err = 1'b0;
`endif

  always_comb begin
    resp_rdata = '0;
    if (resp_valid && !write_q && !trap) begin
      case (size_q)
        2'b00:   resp_rdata = rdata_q;
        2'b01:   resp_rdata = {{16{signed_q & rdata_q[15]}}, rdata_q[15:0]};
        2'b10:   resp_rdata = {{24{signed_q & rdata_q[7]}}, rdata_q[7:0]};
        default: resp_rdata = '0;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk input 1: single clock, all state on rising edge.
REQ-002 SHALL have port rst input 1: asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port req_valid input 1: pipeline presents a load/store request.
REQ-004 SHALL have port req_ready output 1: unit can accept a request this cycle.
REQ-005 SHALL have port req_write input 1: 1 = store, 0 = load.
REQ-006 SHALL have port req_size input 2: 00 word, 01 half, 10 byte, 11 illegal.
REQ-007 SHALL have port req_signed input 1: 1 = sign-extend load result, 0 = zero-extend.
REQ-008 SHALL have port req_addr input 6: byte address of the lowest byte.
REQ-009 SHALL have port req_wdata input 32: store data; bits used by size.
REQ-010 SHALL have port resp_valid output 1: one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata output 32: extended load data, valid with resp_valid.
REQ-012 SHALL have port misalign_err output 1: misaligned-access flag, valid with resp_valid.
REQ-013 SHALL have port mem_read output 1: byte-memory read strobe.
REQ-014 SHALL have port mem_write output 1: byte-memory write strobe; memory writes on rising clk.
REQ-015 SHALL have port mem_addr output 6: byte-memory address.
REQ-016 SHALL have port mem_wdata output 8: byte-memory write data.
REQ-017 SHALL have port mem_rdata input 8: byte-memory combinational read data.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, RESP; req_ready = 1 only in IDLE.
REQ-019 SHALL, on req_valid & req_ready at an edge, latch write, size, signed, addr, wdata, clear byte index to 0, and go to ACCESS (size 11 goes directly to RESP).
REQ-020 SHALL, in ACCESS, issue exactly one byte per cycle: mem_addr = (addr + idx) mod 64, mem_read = !write, mem_write = write, mem_wdata = wdata[8*idx+7:8*idx].
REQ-021 SHALL perform N byte accesses, N = 4/2/1 for word/half/byte, at idx 0..N-1 ascending (little-endian), then go to RESP.
REQ-022 SHALL, on loads, capture mem_rdata into result byte lane idx at the end of each ACCESS cycle.
REQ-023 SHALL, in RESP, assert resp_valid for exactly one cycle and return to IDLE next edge.
REQ-024 SHALL drive resp_rdata in RESP as loaded bytes extended per req_signed from bit 8N-1; stores and size 11 return 0.
REQ-025 SHALL keep mem_read, mem_write, mem_addr, mem_wdata at 0 outside ACCESS.
REQ-026 SHALL give latency accept-edge to resp_valid of N+1 cycles (word 5, half 3, byte 2, illegal 1).
REQ-027 SHALL ignore req_valid while not in IDLE; a request arriving in the RESP cycle waits until IDLE.
REQ-028 SHALL wrap addresses past 63 to 0 without error.

Reset
REQ-029 SHALL, while rst = 0, force state IDLE, idx 0, latched fields 0, req_ready 1, resp_valid 0, resp_rdata 0, misalign_err 0, all mem_* outputs 0.
REQ-030 SHALL, on reset mid-ACCESS, abandon the transfer with no response; bytes already written stay written.

Configuration
REQ-031 SHALL, with MISALIGN_TRAP_EN defined, treat word with addr[1:0] != 0 or half with addr[0] != 0 as misaligned: no memory access, go straight to RESP, resp_rdata 0, misalign_err 1.
REQ-032 SHALL, without MISALIGN_TRAP_EN, tie misalign_err to 0 and perform misaligned accesses bytewise per REQ-020/021.

Verification
REQ-033 SHALL cover: word store addr 4 data 0xA1B2C3D4 -> mem writes 0xD4@4, 0xC3@5, 0xB2@6, 0xA1@7 on 4 consecutive cycles, resp_valid on 5th cycle after accept.
REQ-034 SHALL cover: memory 0x80@10, load byte signed addr 10 -> resp_rdata 0xFFFFFF80; unsigned -> 0x00000080, 2 cycles latency.
REQ-035 SHALL cover: memory 0x34@62, 0x12@63, 0x56@0, 0x78@1, word load addr 62 (macro undefined) -> mem_addr 62,63,0,1, resp_rdata 0x78561234.
REQ-036 SHALL cover: macro defined, half load addr 3 -> no mem strobes, resp_valid 1 cycle after accept, misalign_err 1, resp_rdata 0.
REQ-037 SHALL cover: rst to 0 during 2nd byte of word store addr 8 -> no resp_valid, only byte 8 modified, req_ready 1 immediately.
REQ-038 SHALL cover: back-to-back req_valid held high -> second request accepted only in the cycle after resp_valid, size 11 -> resp_rdata 0 after 1 cycle.
